axi4l_master: RTL and testbench

//  AXI4-Lite initiator. Bridges the core's single-outstanding load/store request port onto AXI4-Lite.

---
 rtl/axi4l_master_if.sv | 34 +++
 rtl/axi4l_master.sv | 139 +++++++++++++
 tb/tb_axi4l_master.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi4l_master_if.sv
// AXI4-Lite bus bundle shared by the initiator and the responding slaves.
interface axi4l_master_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_master.sv
// AXI4-Lite initiator: one outstanding core load/store mapped onto AR/R or
// AW+W/B, with an optional watchdog that turns a hung slave into an error.
module axi4l_master #(
    parameter int TIMEOUT_CYC = 256,
    parameter int TO_W        = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    axi4l_master_if.master m_axi
);

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, AR, WAIT_R, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t          state_q, state_d;
    req_t            req_q;
    logic            aw_done, w_done;
    logic [TO_W-1:0] wd_cnt;

    logic req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic active, wd_expire;

    assign req_ready = (state_q == IDLE);
    assign req_hs    = req_valid & req_ready;
    assign aw_hs     = m_axi.awvalid & m_axi.awready;
    assign w_hs      = m_axi.wvalid  & m_axi.wready;
    assign b_hs      = m_axi.bvalid  & m_axi.bready;
    assign ar_hs     = m_axi.arvalid & m_axi.arready;
    assign r_hs      = m_axi.rvalid  & m_axi.rready;

    assign active    = (state_q == WR) || (state_q == WAIT_B) ||
                       (state_q == AR) || (state_q == WAIT_R);
    assign wd_expire = (TIMEOUT_CYC > 0) && active && (wd_cnt == TO_LAST);

    // AXI payload comes only from the captured request, never from req_*.
    assign m_axi.awaddr  = req_q.addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wdata   = req_q.wdata;
    assign m_axi.wstrb   = req_q.wstrb;
    assign m_axi.araddr  = req_q.addr;
    assign m_axi.arprot  = 3'b000;

    // Valids/readies decode from state; per-channel done flags drop AW/W individually.
    assign m_axi.awvalid = (state_q == WR) && !aw_done;
    assign m_axi.wvalid  = (state_q == WR) && !w_done;
    assign m_axi.bready  = (state_q == WAIT_B);
    assign m_axi.arvalid = (state_q == AR);
    assign m_axi.rready  = (state_q == WAIT_R);
    assign resp_valid    = (state_q == RESP);

    // Only bit 1 of xRESP distinguishes error responses.
    logic unused_resp;
    assign unused_resp = m_axi.bresp[0] ^ m_axi.rresp[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a B/R completion on the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_hs) state_d = req_we ? WR : AR;
            WR: begin
                if (wd_expire)                                   state_d = RESP;
                else if ((aw_done | aw_hs) && (w_done | w_hs))   state_d = WAIT_B;
            end
            WAIT_B: if (b_hs || wd_expire)  state_d = RESP;
            AR: begin
                if (wd_expire)  state_d = RESP;
                else if (ar_hs) state_d = WAIT_R;
            end
            WAIT_R: if (r_hs || wd_expire)  state_d = RESP;
            RESP:   if (resp_ready)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture.
    always_ff @(posedge clk) begin
        if (rst)         req_q <= '0;
        else if (req_hs) req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
    end

    // AW/W completion flags, cleared when a new request is taken.
    always_ff @(posedge clk) begin
        if (rst || req_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state_q == WR) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Watchdog: zero while idle so it starts at 0 on entry to WR/AR.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) wd_cnt <= '0;
        else if (active)            wd_cnt <= wd_cnt + 1'b1;
    end

    // Response capture from B, R or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (state_q == WAIT_B && b_hs) begin
            resp_rdata <= '0;
            resp_err   <= m_axi.bresp[1];
        end else if (state_q == WAIT_R && r_hs) begin
            resp_rdata <= m_axi.rdata;
            resp_err   <= m_axi.rresp[1];
        end else if (wd_expire) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4l_master.sv
// Directed bench for axi4l_master; the bench plays the AXI slave by hand.
module tb_axi4l_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;

    axi4l_master_if axi();

    axi4l_master #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    // {awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready}
    logic [6:0] ctl;
    assign ctl = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, resp_valid, req_ready};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        resp_ready = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        step(); step();
        @(negedge clk);
        chk("rst_ctl", 32'(ctl), 32'h01);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        step(); rst = 1'b0;

        // 1: zero-wait read
        req_valid = 1; req_we = 0; req_addr = 32'h10; axi.arready = 1; resp_ready = 1;
        @(negedge clk); chk("t1_req_ready", 32'(req_ready), 32'h1);
        step(); req_valid = 0;
        @(negedge clk); chk("t1_arvalid_c1", 32'(axi.arvalid), 32'h1);
        chk("t1_araddr", axi.araddr, 32'h10);
        chk("t1_arprot", 32'(axi.arprot), 32'h0);
        step(); axi.rvalid = 1; axi.rdata = 32'h1234_5678; axi.rresp = 2'b00;
        @(negedge clk); chk("t1_ctl_c2", 32'(ctl), 32'h04);
        step(); axi.rvalid = 0;
        @(negedge clk); chk("t1_resp_valid_c3", 32'(resp_valid), 32'h1);
        chk("t1_rdata", resp_rdata, 32'h1234_5678);
        chk("t1_err", 32'(resp_err), 32'h0);
        step(); resp_ready = 0;
        @(negedge clk); chk("t1_idle", 32'(ctl), 32'h01);

        // 2: write, W accepted three cycles before AW
        step(); req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5;
        req_wstrb = 4'b0011; axi.arready = 0; axi.awready = 0; axi.wready = 1;
        step(); req_valid = 0; req_wdata = 0; req_wstrb = 0; req_addr = 0;
        @(negedge clk); chk("t2_ctl_c1", 32'(ctl), 32'h60);
        chk("t2_awaddr", axi.awaddr, 32'h20);
        chk("t2_wdata", axi.wdata, 32'hA5A5_A5A5);
        chk("t2_wstrb", 32'(axi.wstrb), 32'h3);
        step(); axi.wready = 0;
        @(negedge clk); chk("t2_ctl_c2", 32'(ctl), 32'h40);
        chk("t2_awaddr_hold", axi.awaddr, 32'h20);
        step();
        @(negedge clk); chk("t2_ctl_c3", 32'(ctl), 32'h40);
        step(); axi.awready = 1;
        @(negedge clk); chk("t2_ctl_c4", 32'(ctl), 32'h40);
        step(); axi.awready = 0; axi.bvalid = 1; axi.bresp = 2'b00;
        @(negedge clk); chk("t2_ctl_c5", 32'(ctl), 32'h10);
        step(); axi.bvalid = 0; resp_ready = 1;
        @(negedge clk); chk("t2_ctl_c6", 32'(ctl), 32'h02);
        chk("t2_err", 32'(resp_err), 32'h0);
        chk("t2_rdata", resp_rdata, 32'h0);
        step(); resp_ready = 0;
        @(negedge clk); chk("t2_idle", 32'(ctl), 32'h01);

        // 3: bvalid stuck high, AW at c3, W at c5, SLVERR on B
        step(); req_valid = 1; req_we = 1; req_addr = 32'h30; req_wdata = 32'h0F0F_0F0F;
        req_wstrb = 4'hF; axi.bvalid = 1; axi.bresp = 2'b10;
        step(); req_valid = 0;
        @(negedge clk); chk("t3_ctl_c1", 32'(ctl), 32'h60);
        step();
        @(negedge clk); chk("t3_ctl_c2", 32'(ctl), 32'h60);
        step(); axi.awready = 1;
        @(negedge clk); chk("t3_ctl_c3", 32'(ctl), 32'h60);
        step(); axi.awready = 0;
        @(negedge clk); chk("t3_ctl_c4", 32'(ctl), 32'h20);
        step(); axi.wready = 1;
        @(negedge clk); chk("t3_ctl_c5", 32'(ctl), 32'h20);
        step(); axi.wready = 0;
        @(negedge clk); chk("t3_ctl_c6", 32'(ctl), 32'h10);
        step(); resp_ready = 1;
        @(negedge clk); chk("t3_ctl_c7", 32'(ctl), 32'h02);
        chk("t3_err", 32'(resp_err), 32'h1);
        step(); resp_ready = 0;
        @(negedge clk); chk("t3_idle", 32'(ctl), 32'h01);
        axi.bvalid = 0; axi.bresp = 0;

        // 4: read SLVERR, core stalls the response for 5 cycles
        step(); req_valid = 1; req_we = 0; req_addr = 32'h40; axi.arready = 1;
        step(); req_valid = 0;
        step(); axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b10;
        step(); axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_ctl", 32'(ctl), 32'h02);
            chk("t4_hold_rdata", resp_rdata, 32'hDEAD_BEEF);
            chk("t4_hold_err", 32'(resp_err), 32'h1);
            step();
        end
        resp_ready = 1;
        @(negedge clk); chk("t4_resp_c8", 32'(resp_valid), 32'h1);
        step(); resp_ready = 0;
        @(negedge clk); chk("t4_idle", 32'(ctl), 32'h01);

        // 5: arready never comes; watchdog fires after 16 cycles of arvalid
        step(); req_valid = 1; req_we = 0; req_addr = 32'h50; axi.arready = 0;
        step(); req_valid = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("t5_arvalid_held", 32'(axi.arvalid), 32'h1);
            step();
        end
        resp_ready = 1;
        @(negedge clk); chk("t5_ctl_c17", 32'(ctl), 32'h02);
        chk("t5_err", 32'(resp_err), 32'h1);
        chk("t5_rdata", resp_rdata, 32'h0);
        step(); resp_ready = 0; req_valid = 1; req_addr = 32'h60; axi.arready = 1;
        @(negedge clk); chk("t5_next_ready", 32'(req_ready), 32'h1);
        step(); req_valid = 0;
        @(negedge clk); chk("t5_next_araddr", axi.araddr, 32'h60);
        step(); axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D;
        step(); axi.rvalid = 0; resp_ready = 1;
        @(negedge clk); chk("t5_next_rdata", resp_rdata, 32'h0BAD_F00D);
        chk("t5_next_err", 32'(resp_err), 32'h0);
        step(); resp_ready = 0;

        // 6: reset while waiting for R
        step(); req_valid = 1; req_addr = 32'h70; axi.arready = 1;
        step(); req_valid = 0;
        step();
        @(negedge clk); chk("t6_ctl_wait_r", 32'(ctl), 32'h04);
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk); chk("t6_ctl_after_rst", 32'(ctl), 32'h01);
        chk("t6_rdata_after_rst", resp_rdata, 32'h0);
        chk("t6_err_after_rst", 32'(resp_err), 32'h0);
        step(); req_valid = 1; req_addr = 32'h80;
        step(); req_valid = 0;
        @(negedge clk); chk("t6_araddr", axi.araddr, 32'h80);
        step(); axi.rvalid = 1; axi.rdata = 32'hCAFE_F00D;
        step(); axi.rvalid = 0; resp_ready = 1;
        @(negedge clk); chk("t6_resp_valid", 32'(resp_valid), 32'h1);
        chk("t6_rdata", resp_rdata, 32'hCAFE_F00D);
        step(); resp_ready = 0;
        @(negedge clk); chk("t6_idle", 32'(ctl), 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
